// File: rtl/disp_counter_gen2.sv
// disp_counter_gen2: value generator for the 6-digit 7-segment display path.
// A run/pause/idle FSM gates a tick divider; each tick adds or subtracts a
// runtime step to a signed value. Values are kept in lo..hi, either wrapping
// or saturating at the bounds. Magnitude, sign, decimal point and enable are
// registered for the segment driver.
// There is no valid/ready handshake: start/stop/clear/load are single-cycle
// command pulses sampled on every clk edge, highest priority first.
module disp_counter_gen2 #(
   parameter int DATA_W    = 20,
   parameter int TICK_DIV  = 5_000_000,
   parameter int MAX_VAL   = 999999,
   parameter bit SIGNED_EN = 1'b0,
   parameter bit WRAP_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_val,
   input  logic              load_neg,
   input  logic              dir,
   input  logic [7:0]        step,
   input  logic [2:0]        point_sel,
   input  logic              blank,
   output logic [DATA_W-1:0] data,
   output logic              sign,
   output logic [5:0]        point,
   output logic              en,
   output logic              running,
   output logic              bound,
   output logic [1:0]        state_dbg
);

   // Value register is signed with one extra bit for the sign.
   localparam int VW = DATA_W + 1;
   // Arithmetic width: two bits over the value, but never narrower than the
   // 8-bit step plus sign and carry, so value +/- step cannot overflow.
   localparam int CW = (DATA_W + 2 > 10) ? DATA_W + 2 : 10;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [DATA_W-1:0] MAX_U = DATA_W'(MAX_VAL);
   localparam logic signed [CW-1:0] HI = CW'(MAX_VAL);
   localparam logic signed [CW-1:0] LO = SIGNED_EN ? -HI : '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic signed [VW-1:0]   value_q, value_d;
   logic signed [VW-1:0]   value_abs;
   logic                   bound_d;
   logic                   advance;
   logic                   tick;
   logic [DATA_W-1:0]      load_mag;
   logic signed [CW-1:0]   load_ext;
   logic signed [CW-1:0]   cur_ext;
   logic signed [CW-1:0]   step_ext;
   logic signed [CW-1:0]   nxt;
   logic [5:0]             point_d;

   assign state_dbg = state_q;

   // Next state: clear beats stop beats start; stop outside RUN is a no-op.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else if (stop) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (start) begin
         state_d = ST_RUN;
      end
   end

   // Divider advances only while running; a stop edge freezes it in place.
   always_comb begin
      advance = (state_q == ST_RUN) && !stop && !clear;
      tick    = advance && (div_q == DIV_LAST);
      div_d   = div_q;
      if (clear) begin
         div_d = '0;
      end else if (advance) begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
      end
   end

   // Value update: clear, then load, then a tick step with wrap/saturate.
   always_comb begin
      load_mag = (load_val > MAX_U) ? MAX_U : load_val;
      load_ext = signed'({{(CW - DATA_W){1'b0}}, load_mag});
      if (load_neg && SIGNED_EN) load_ext = -load_ext;
      cur_ext  = signed'({{(CW - VW){value_q[VW-1]}}, value_q});
      step_ext = signed'({{(CW - 8){1'b0}}, step});
      nxt      = dir ? (cur_ext - step_ext) : (cur_ext + step_ext);
      value_d  = value_q;
      bound_d  = 1'b0;
      if (clear) begin
         value_d = '0;
      end else if (load) begin
         value_d = load_ext[VW-1:0];
      end else if (tick) begin
         if (!dir && (nxt > HI)) begin
            bound_d = 1'b1;
            value_d = WRAP_EN ? LO[VW-1:0] : HI[VW-1:0];
         end else if (dir && (nxt < LO)) begin
            bound_d = 1'b1;
            value_d = WRAP_EN ? HI[VW-1:0] : LO[VW-1:0];
         end else begin
            value_d = nxt[VW-1:0];
         end
      end
      value_abs = value_d[VW-1] ? -value_d : value_d;
   end

   // One-hot decimal point; codes 0 and 7 light nothing.
   always_comb begin
      point_d = '0;
      case (point_sel)
         3'd1:    point_d = 6'b000001;
         3'd2:    point_d = 6'b000010;
         3'd3:    point_d = 6'b000100;
         3'd4:    point_d = 6'b001000;
         3'd5:    point_d = 6'b010000;
         3'd6:    point_d = 6'b100000;
         default: point_d = '0;
      endcase
   end

   // Internal state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         value_q <= value_d;
      end
   end

   // Registered display outputs, updated on the same edge as the value.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         sign    <= 1'b0;
         point   <= '0;
         en      <= 1'b0;
         running <= 1'b0;
         bound   <= 1'b0;
      end else begin
         data    <= value_abs[DATA_W-1:0];
         sign    <= value_d[VW-1];
         point   <= point_d;
         en      <= ~blank;
         running <= (state_d == ST_RUN);
         bound   <= bound_d;
      end
   end

endmodule

// File: doc/disp_counter_gen2.md
Name: disp_counter_gen2

Overview:
- Parametrised value generator for the 6-digit dynamic 7-segment display path. Feeds data, sign, point and en to the segment driver.
- Generalises the fixed 0..999999 free-running counter. Adds configurable tick period and range, an up/down direction, a runtime step size, start/stop/clear/load control, a signed range, selectable decimal point, blanking, and wrap or saturate behaviour with a boundary pulse.

Parameters:
- DATA_W, 20, width of the magnitude output.
- TICK_DIV, 5_000_000, clk cycles per count step (100 ms at 50 MHz). Must be ≥2.
- MAX_VAL, 999999, maximum magnitude. Must be < 2^DATA_W.
- SIGNED_EN, 0: 1 gives range −MAX_VAL..+MAX_VAL; 0 gives range 0..MAX_VAL.
- WRAP_EN, 1: 1 wraps at a bound; 0 saturates at a bound.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; enter RUN
- stop  in  1  pulse; enter PAUSE
- clear  in  1  pulse; value:=0, divider:=0, enter IDLE
- load  in  1  pulse; value:=±load_val
- load_val  in  DATA_W  load magnitude; clamped to MAX_VAL
- load_neg  in  1  load sign; ignored if SIGNED_EN=0
- dir  in  1  0 = count up, 1 = count down
- step  in  8  increment per tick; 0 means no change
- point_sel  in  3  0 = no point; 1..6 lights point[point_sel-1]; 7 = no point
- blank  in  1  1 forces en low
- data  out  DATA_W  |value|
- sign  out  1  1 when value<0
- point  out  6  one-hot decimal point
- en  out  1  display enable
- running  out  1  state==RUN
- bound  out  1  one-cycle pulse on a wrap or saturate event

Behaviour:
- All outputs are registered. Reset values: data=0, sign=0, point=0, en=0, running=0, bound=0, state=IDLE, divider=0, value=0.
- Reset is sampled only on a clk edge and overrides every other input.

State machine (IDLE, RUN, PAUSE):
- IDLE --start--> RUN.
- RUN --stop--> PAUSE.
- PAUSE --start--> RUN.
- Any state --clear--> IDLE.
- start while in RUN, or stop while in IDLE/PAUSE, has no effect.

Priority within one cycle: rst > clear > load > stop > start > tick step.
- load with start: value is loaded and state goes to RUN. No step in that cycle.
- clear with anything else: clear wins.

Divider:
- Counts 0..TICK_DIV−1 only in RUN. Holds its value in PAUSE. Cleared by clear or rst.
- tick is asserted when divider==TICK_DIV−1 in RUN. On that edge the divider returns to 0 and a step is applied.
- First step occurs TICK_DIV edges after the start edge.

Step arithmetic:
- Internal value is signed, DATA_W+1 bits. Compute with DATA_W+2 bits to avoid overflow.
- lo = −MAX_VAL if SIGNED_EN else 0; hi = MAX_VAL.
- Up: n = value+step. If n>hi: WRAP_EN gives value:=lo, otherwise value:=hi. In both cases bound=1 for one cycle.
- Down: n = value−step. If n<lo: WRAP_EN gives value:=hi, otherwise value:=lo. bound=1.
- A boundary is crossed only if n exceeds the bound. Landing exactly on hi/lo is not a bound event.
- Wrap goes to the opposite bound exactly; the residue is discarded.
- Saturating at a bound while already at that bound (step>0) still pulses bound on every tick.
- step=0: tick still consumed, value unchanged, no bound pulse.

Load:
- value := min(load_val, MAX_VAL), negated if load_neg && SIGNED_EN.
- load does not touch the divider or the state (except when combined with start, as above).

Output mapping:
- data and sign update on the same edge as value: data=|value|, sign=(value<0).
- −0 is impossible; sign=0 whenever data=0.
- point is registered from point_sel with 1-cycle latency.
- en = ~blank, registered with 1-cycle latency; en is 0 during reset.
- running reflects the state after the edge.

Test Plan (TICK_DIV=4, MAX_VAL=15, DATA_W=4 unless noted):
- rst, then start, step=1, dir=0 → data steps 0,1,2,… every 4 cycles; first change 4 edges after start; running=1, en=1, sign=0.
- Up, WRAP_EN=1, SIGNED_EN=0, load 14, step=3 → next tick data=0, bound pulses for 1 cycle. Repeat with WRAP_EN=0 → data=15, bound pulses on each subsequent tick.
- SIGNED_EN=1, load 2 (load_neg=0), dir=1, step=1 → data/sign sequence 2/0, 1/0, 0/0, 1/1, 2/1. At −15 with a further step → wraps to 15/0 with a bound pulse.
- stop mid-divide at divider=2, wait 10 cycles, start → next step 2 cycles later, value held during PAUSE.
- Same-cycle clear+load+start → data=0, state IDLE, no steps thereafter. Same-cycle load 7 + start → data=7, first step 4 cycles later.
- point_sel 0..7 → point 000000, 000001, … 100000, 000000, each 1 cycle late. blank=1 → en=0 next cycle. Reset asserted mid-RUN → all outputs return to reset values on the next edge.
